// File: rtl/cache_sa_wb_pkg.sv
// rtl/cache_sa_wb_pkg.sv - state encoding and width helper shared by the cache_sa_wb files
package cache_sa_wb_pkg;

    typedef enum logic [1:0] {
        CACHE_IDLE = 2'd0,
        CACHE_WB   = 2'd1,
        CACHE_FILL = 2'd2
    } cache_state_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/cache_sa_wb_way.sv
// rtl/cache_sa_wb_way.sv - one way of the cache: data/tag/valid/dirty arrays with per-index lookup
module cache_sa_wb_way
    import cache_sa_wb_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4,
    localparam int OFF_BITS   = log2(BLOCK_WORDS),
    localparam int IDX_BITS   = log2(SETS),
    localparam int TAG_BITS   = WORD_SIZE - IDX_BITS - OFF_BITS,
    localparam int BLK        = BLOCK_WORDS * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  index,
    input  logic [TAG_BITS-1:0]  tag,
    output logic                 hit,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag_out,
    output logic [BLK-1:0]       block,
    input  logic                 write_en,
    input  logic [OFF_BITS-1:0]  write_off,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic                 fill_en,
    input  logic [BLK-1:0]       fill_data,
    input  logic                 clean_en
);

    logic [BLK-1:0]      data_q [SETS];
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;

    assign valid   = valid_q[index];
    assign dirty   = dirty_q[index];
    assign tag_out = tag_q[index];
    assign block   = data_q[index];
    assign hit     = valid_q[index] && (tag_q[index] == tag);

    // Payload arrays carry no reset; only valid/dirty define whether a line exists.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[index] <= fill_data;
            tag_q[index]  <= tag;
        end else if (write_en) begin
            data_q[index][write_off*WORD_SIZE +: WORD_SIZE] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (write_en) begin
            dirty_q[index] <= 1'b1;
        end else if (clean_en) begin
            dirty_q[index] <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_sa_wb.sv
// rtl/cache_sa_wb.sv - set-associative write-back write-allocate cache with LRU replacement
module cache_sa_wb
    import cache_sa_wb_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int SETS        = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WAYS        = 2,
    localparam int OFF_BITS   = log2(BLOCK_WORDS),
    localparam int IDX_BITS   = log2(SETS),
    localparam int TAG_BITS   = WORD_SIZE - IDX_BITS - OFF_BITS,
    localparam int BLK        = BLOCK_WORDS * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readC,
    input  logic                 writeC,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 readyC,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] addressM,
    input  logic                 input_readyM,
    input  logic                 doneM,
    inout  wire  [BLK-1:0]       dataM,
    output logic [WORD_SIZE-1:0] num_cache_access,
    output logic [WORD_SIZE-1:0] num_cache_miss
);

    logic [TAG_BITS-1:0] tag;
    logic [IDX_BITS-1:0] idx;
    logic [OFF_BITS-1:0] off;

    assign tag = address[WORD_SIZE-1 -: TAG_BITS];
    assign idx = address[OFF_BITS +: IDX_BITS];
    assign off = address[OFF_BITS-1:0];

    cache_state_t state_q, state_d;

    logic [WAYS-1:0]     way_hit, way_valid, way_dirty, way_write, way_fill, way_clean;
    logic [TAG_BITS-1:0] way_tag [WAYS];
    logic [BLK-1:0]      way_blk [WAYS];
    logic [SETS-1:0]     lru_q;
    logic                hit, req, miss_start, hit_way, victim_sel, victim_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_sa_wb_way #(
            .WORD_SIZE   (WORD_SIZE),
            .SETS        (SETS),
            .BLOCK_WORDS (BLOCK_WORDS)
        ) u_way (
            .clk        (clk),
            .reset      (reset),
            .index      (idx),
            .tag        (tag),
            .hit        (way_hit[w]),
            .valid      (way_valid[w]),
            .dirty      (way_dirty[w]),
            .tag_out    (way_tag[w]),
            .block      (way_blk[w]),
            .write_en   (way_write[w]),
            .write_off  (off),
            .write_data (data),
            .fill_en    (way_fill[w]),
            .fill_data  (dataM),
            .clean_en   (way_clean[w])
        );

        assign way_write[w] = readyC && writeC && (hit_way == 1'(w));
        assign way_fill[w]  = (state_q == CACHE_FILL) && input_readyM && (victim_q == 1'(w));
        assign way_clean[w] = (state_q == CACHE_WB) && doneM && (victim_q == 1'(w));
    end

    // lru_q[set] names the way to replace next, so it flips away from every hit.
    if (WAYS == 2) begin : g_assoc
        assign hit_way    = way_hit[1];
        assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[idx]);
    end else begin : g_direct
        assign hit_way    = 1'b0;
        assign victim_sel = 1'b0;
    end

    assign hit        = |way_hit;
    assign req        = readC || writeC;
    assign miss_start = (state_q == CACHE_IDLE) && req && !hit;

    always_comb begin
        state_d = state_q;
        readyC  = 1'b0;
        readM   = 1'b0;
        writeM  = 1'b0;
        case (state_q)
            CACHE_IDLE: begin
                readyC = req && hit;
                if (miss_start)
                    state_d = (way_valid[victim_sel] && way_dirty[victim_sel]) ? CACHE_WB : CACHE_FILL;
            end
            CACHE_WB: begin
                writeM = 1'b1;
                if (doneM) state_d = CACHE_FILL;
            end
            CACHE_FILL: begin
                readM = 1'b1;
                if (input_readyM) state_d = CACHE_IDLE;
            end
            default: state_d = CACHE_IDLE;
        endcase
    end

    assign addressM = (state_q == CACHE_WB) ? {way_tag[victim_q], idx, {OFF_BITS{1'b0}}}
                                            : {tag, idx, {OFF_BITS{1'b0}}};
    assign dataM    = writeM ? way_blk[victim_q] : {BLK{1'bz}};
    assign data     = (readC && readyC) ? way_blk[hit_way][off*WORD_SIZE +: WORD_SIZE]
                                        : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= CACHE_IDLE;
            lru_q            <= '0;
            victim_q         <= 1'b0;
            num_cache_access <= '0;
            num_cache_miss   <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                victim_q       <= victim_sel;
                num_cache_miss <= num_cache_miss + 1'b1;
            end
            if (readyC) begin
                lru_q[idx]       <= ~hit_way;
                num_cache_access <= num_cache_access + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_sa_wb.sv
// tb/tb_cache_sa_wb.sv - self-checking bench for cache_sa_wb with memory responder and reference model
module tb_cache_sa_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        readC = 1'b0;
    logic        writeC = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] wdata = '0;
    wire  [15:0] data;
    logic        readyC, readM, writeM;
    logic [15:0] addressM, num_cache_access, num_cache_miss;
    logic        input_readyM = 1'b0;
    logic        doneM = 1'b0;
    wire  [63:0] dataM;
    logic [63:0] mem_blk = '0;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];

    int passed = 0;
    int total = 0;
    int wait_cnt = 0;
    bit mem_hold = 1'b0;
    int wb_count = 0;
    int fill_count = 0;
    logic [15:0] last_wb_addr = '0;
    logic [15:0] last_fill_addr = '0;

    logic [11:0] m_tag   [4][2];
    bit          m_dirty [4][2];
    int          m_n     [4];
    int          m_acc = 0;
    int          m_mis = 0;

    cache_sa_wb dut (
        .clk              (clk),
        .reset            (reset),
        .readC            (readC),
        .writeC           (writeC),
        .address          (address),
        .data             (data),
        .readyC           (readyC),
        .readM            (readM),
        .writeM           (writeM),
        .addressM         (addressM),
        .input_readyM     (input_readyM),
        .doneM            (doneM),
        .dataM            (dataM),
        .num_cache_access (num_cache_access),
        .num_cache_miss   (num_cache_miss)
    );

    always #5 clk = ~clk;

    assign data  = writeC ? wdata : 16'bz;
    assign dataM = readM ? mem_blk : 64'bz;

    // Block memory with a random 0..3 cycle latency per transfer.
    always @(posedge clk) begin
        #2;
        if (input_readyM || doneM) begin
            input_readyM = 1'b0;
            doneM = 1'b0;
            wait_cnt = $urandom_range(0, 3);
        end else if ((readM || writeM) && !mem_hold && !reset) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else if (writeM) begin
                for (int w = 0; w < 4; w++) mem[{addressM[15:2], 2'(w)}] = dataM[w*16 +: 16];
                wb_count++;
                last_wb_addr = addressM;
                doneM = 1'b1;
            end else begin
                for (int w = 0; w < 4; w++) mem_blk[w*16 +: 16] = mem[{addressM[15:2], 2'(w)}];
                fill_count++;
                last_fill_addr = addressM;
                input_readyM = 1'b1;
            end
        end else begin
            wait_cnt = $urandom_range(0, 3);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reinit();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A00;
            ref_mem[i] = 16'(i) ^ 16'h5A00;
        end
        for (int s = 0; s < 4; s++) m_n[s] = 0;
        m_acc = 0;
        m_mis = 0;
    endtask

    // Reference: per set an MRU-first list of at most two resident blocks.
    task automatic model_access(input bit wr, input logic [15:0] a,
                                output bit miss, output bit wb, output logic [15:0] wb_a);
        int s;
        int pos;
        logic [11:0] t;
        logic [11:0] tt;
        bit dd;
        s = int'(a[3:2]);
        t = a[15:4];
        pos = -1;
        for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) pos = i;
        miss = (pos < 0);
        wb = 1'b0;
        wb_a = '0;
        if (miss) begin
            if (m_n[s] == 2) begin
                wb = m_dirty[s][1];
                wb_a = {m_tag[s][1], a[3:2], 2'b00};
            end else begin
                m_n[s]++;
            end
            m_tag[s][1] = m_tag[s][0];
            m_dirty[s][1] = m_dirty[s][0];
            m_tag[s][0] = t;
            m_dirty[s][0] = 1'b0;
        end else if (pos == 1) begin
            tt = m_tag[s][0];
            dd = m_dirty[s][0];
            m_tag[s][0] = m_tag[s][1];
            m_dirty[s][0] = m_dirty[s][1];
            m_tag[s][1] = tt;
            m_dirty[s][1] = dd;
        end
        if (wr) m_dirty[s][0] = 1'b1;
        m_acc++;
        if (miss) m_mis++;
    endtask

    task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat, output bit done, output bit bad);
        @(negedge clk);
        address = a;
        wdata = wd;
        readC = !wr;
        writeC = wr;
        done = 1'b0;
        bad = 1'b0;
        lat = 0;
        rd = '0;
        while (!done && lat < 200) begin
            #1;
            if (readM && writeM) bad = 1'b1;
            if (readyC && (readM || writeM)) bad = 1'b1;
            if (readyC) begin
                done = 1'b1;
                rd = data;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        readC = 1'b0;
        writeC = 1'b0;
    endtask

    task automatic run_check(input string name, input bit wr, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] exp_rd,
                             input bit exp_miss, input bit exp_wb, input logic [15:0] exp_wb_a);
        int wb0, f0, lat;
        bit done, bad;
        logic [15:0] rd;
        logic [63:0] got_b, exp_b;
        wb0 = wb_count;
        f0 = fill_count;
        do_req(wr, a, wd, rd, lat, done, bad);
        check({name, " readyC"}, 64'(done), 64'd1);
        check({name, " protocol"}, 64'(bad), 64'd0);
        if (!wr) check({name, " data"}, 64'(rd), 64'(exp_rd));
        check({name, " fills"}, 64'(fill_count - f0), 64'(exp_miss));
        if (exp_miss) check({name, " fill addr"}, 64'(last_fill_addr), 64'({a[15:2], 2'b00}));
        else check({name, " hit latency"}, 64'(lat), 64'd0);
        check({name, " writebacks"}, 64'(wb_count - wb0), 64'(exp_wb));
        if (exp_wb) begin
            check({name, " wb addr"}, 64'(last_wb_addr), 64'(exp_wb_a));
            for (int w = 0; w < 4; w++) begin
                got_b[w*16 +: 16] = mem[exp_wb_a + 16'(w)];
                exp_b[w*16 +: 16] = ref_mem[exp_wb_a + 16'(w)];
            end
            check({name, " wb data"}, got_b, exp_b);
        end
        if (wr) ref_mem[a] = wd;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        bit          miss;
        bit          wb;
        logic [15:0] wb_a;
        logic [15:0] acc;
        logic [15:0] mis;
    } vec_t;

    vec_t vecs [11];

    initial begin
        bit seen, miss, wb;
        logic [15:0] wb_a, a;
        bit wr;
        logic [15:0] wd;

        vecs[0]  = '{1'b0, 16'h0012, 16'h0000, 16'h5A12, 1'b1, 1'b0, 16'h0000, 16'd1,  16'd1};
        vecs[1]  = '{1'b0, 16'h0013, 16'h0000, 16'h5A13, 1'b0, 1'b0, 16'h0000, 16'd2,  16'd1};
        vecs[2]  = '{1'b1, 16'h0011, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd3,  16'd1};
        vecs[3]  = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'd4,  16'd1};
        vecs[4]  = '{1'b0, 16'h0050, 16'h0000, 16'h5A50, 1'b1, 1'b0, 16'h0000, 16'd5,  16'd2};
        vecs[5]  = '{1'b0, 16'h0090, 16'h0000, 16'h5A90, 1'b1, 1'b1, 16'h0010, 16'd6,  16'd3};
        vecs[6]  = '{1'b0, 16'h0010, 16'h0000, 16'h5A10, 1'b1, 1'b0, 16'h0000, 16'd7,  16'd4};
        vecs[7]  = '{1'b1, 16'h0102, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'd8,  16'd5};
        vecs[8]  = '{1'b0, 16'h0102, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'd9,  16'd5};
        vecs[9]  = '{1'b0, 16'h0202, 16'h0000, 16'h5802, 1'b1, 1'b0, 16'h0000, 16'd10, 16'd6};
        vecs[10] = '{1'b0, 16'h0302, 16'h0000, 16'h5902, 1'b1, 1'b1, 16'h0100, 16'd11, 16'd7};

        reinit();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset readM", 64'(readM), 64'd0);
        check("reset writeM", 64'(writeM), 64'd0);
        check("reset readyC", 64'(readyC), 64'd0);
        check("reset access", 64'(num_cache_access), 64'd0);
        check("reset miss", 64'(num_cache_miss), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].rd,
                      vecs[i].miss, vecs[i].wb, vecs[i].wb_a);
            #1;
            check($sformatf("vec%0d access", i), 64'(num_cache_access), 64'(vecs[i].acc));
            check($sformatf("vec%0d misses", i), 64'(num_cache_miss), 64'(vecs[i].mis));
        end

        // Reset while a fill is outstanding.
        mem_hold = 1'b1;
        @(negedge clk);
        address = 16'h0012;
        readC = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = readM;
        end
        check("rst-fill readM seen", 64'(seen), 64'd1);
        check("rst-fill addressM", 64'(addressM), 64'h0010);
        @(negedge clk);
        reset = 1'b1;
        readC = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst-fill readM after", 64'(readM), 64'd0);
        check("rst-fill writeM after", 64'(writeM), 64'd0);
        check("rst-fill access", 64'(num_cache_access), 64'd0);
        check("rst-fill misses", 64'(num_cache_miss), 64'd0);
        mem_hold = 1'b0;
        reinit();
        run_check("rst-fill reread", 1'b0, 16'h0012, 16'h0, 16'h5A12, 1'b1, 1'b0, 16'h0);
        #1;
        check("rst-fill reread misses", 64'(num_cache_miss), 64'd1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reinit();
        for (int n = 0; n < 400; n++) begin
            a = {12'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wr = ($urandom_range(0, 2) == 0);
            wd = 16'($urandom);
            model_access(wr, a, miss, wb, wb_a);
            run_check($sformatf("rnd%0d", n), wr, a, wd, ref_mem[a], miss, wb, wb_a);
            #1;
            check($sformatf("rnd%0d access", n), 64'(num_cache_access), 64'(m_acc));
            check($sformatf("rnd%0d misses", n), 64'(num_cache_miss), 64'(m_mis));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
